// File: rtl/scp_arb_pkg.sv
// Shared types and constants for the scratchpad memory arbiter.
package scp_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {SRC_IF, SRC_D} src_t;

    localparam int unsigned ARB_CNT_W = 32;

    function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
        return (&v) ? v : v + ARB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/scp_arb_pick.sv
// Combinational round-robin picker: a tie goes to the source not served last.
module scp_arb_pick
    import scp_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  src_t last_src,
    output logic grant_valid,
    output src_t grant_src
);

    always_comb begin
        grant_valid = if_req | d_req;
        if (if_req && d_req) begin
            grant_src = (last_src == SRC_IF) ? SRC_D : SRC_IF;
        end else if (d_req) begin
            grant_src = SRC_D;
        end else begin
            grant_src = SRC_IF;
        end
    end

endmodule

// File: rtl/scp_mem_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store requesters.
// Define SCP_ARB_PERF_CNT_EN to add internal grant/conflict/stall counters.
module scp_mem_arbiter
    import scp_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("scp_mem_arbiter: MEM_LAT must be at least 1");
    end

    arb_state_t        state_q;
    src_t              last_src_q;
    src_t              src_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic grant_valid;
    src_t grant_src;
    logic idle;
    logic grant_fire;

    scp_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_src    (last_src_q),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    assign idle       = (state_q == IDLE);
    assign grant_fire = idle & grant_valid;
    assign if_gnt     = grant_fire & (grant_src == SRC_IF);
    assign d_gnt      = grant_fire & (grant_src == SRC_D);

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_src_q  <= SRC_IF;
            src_q       <= SRC_IF;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q    <= ACCESS;
                        src_q      <= grant_src;
                        last_src_q <= grant_src;
                        cnt_q      <= CNT_W'(MEM_LAT - 1);
                        mem_en_q   <= 1'b1;
                        if (grant_src == SRC_D) begin
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        // Stores still pulse d_rvalid as an ack, with zero data.
                        if (src_q == SRC_IF) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= mem_we_q ? '0 : mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCP_ARB_PERF_CNT_EN
    logic [ARB_CNT_W-1:0] if_gnt_cnt;
    logic [ARB_CNT_W-1:0] d_gnt_cnt;
    logic [ARB_CNT_W-1:0] conflict_cnt;
    logic [ARB_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_gnt_cnt   <= '0;
            d_gnt_cnt    <= '0;
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (if_gnt)                   if_gnt_cnt   <= sat_inc(if_gnt_cnt);
            if (d_gnt)                    d_gnt_cnt    <= sat_inc(d_gnt_cnt);
            if (idle && if_req && d_req)  conflict_cnt <= sat_inc(conflict_cnt);
            if (!idle && (if_req || d_req)) stall_cnt  <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule
